// File: rtl/cart_config_bank_pkg.sv
// Shared constants for the cart configuration register bank: status word layout
// and the width of the N64 reset event counter.
package cart_config_bank_pkg;

    localparam int EVENT_COUNT_W      = 8;
    localparam int STATUS_COUNT_LSB   = 0;
    localparam int STATUS_PENDING_LSB = 16;
    localparam int STATUS_PENDING_W   = 16;

endpackage

// File: rtl/cart_config_edge_detect.sv
// Two-input rising-edge detector producing a single event strobe; a clear marks
// both inputs as already high so a level present at release is not an edge.
module cart_config_edge_detect (
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_a,
    input  logic i_b,
    output logic o_event
);

    logic a_p1;
    logic b_p1;

    // History tracks the inputs every cycle, independent of the enable
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            a_p1 <= 1'b1;
            b_p1 <= 1'b1;
        end else begin
            a_p1 <= i_a;
            b_p1 <= i_b;
        end
    end

    assign o_event = i_enable && !i_clear && ((i_a && !a_p1) || (i_b && !b_p1));

endmodule

// File: rtl/cart_config_bank.sv
// Cart configuration register bank on the PI/CPU bus: masked config words with
// deferred bits that commit on N64 reset/NMI events, plus a read-only status word.
module cart_config_bank
    import cart_config_bank_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 4,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUE    = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] WRITE_MASK     = '1,
    parameter logic [NUM_REGS*DATA_W-1:0] N64_CLEAR_MASK = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] DEFER_MASK     = '0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_n64_reset,
    input  logic                       i_n64_nmi,
    input  logic                       i_n64_disabled,
    input  logic                       i_select,
    input  logic                       i_read_rq,
    input  logic                       i_write_rq,
    input  logic [31:0]                i_address,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_ack,
    output logic [DATA_W-1:0]          o_data,
    output logic [NUM_REGS*DATA_W-1:0] o_config,
    output logic                       o_n64_event
);

    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

    function automatic logic [EVENT_COUNT_W-1:0] sat_inc(input logic [EVENT_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                     req;
    logic                     wr_en;
    logic [IDX_W-1:0]         idx;
    logic                     n64_evt;
    logic [DATA_W-1:0]        cfg_w [NUM_REGS];
    logic [NUM_REGS-1:0]      pend_w;
    logic [EVENT_COUNT_W-1:0] evt_cnt_q;
    logic [DATA_W-1:0]        status_word;
    logic [DATA_W-1:0]        rd_word;
    logic                     ack_p1;
    logic                     n64_event_p1;
    logic [DATA_W-1:0]        rd_data_p1;
    logic                     unused_addr_bits;

    assign req   = i_select && (i_read_rq || i_write_rq);
    assign wr_en = i_select && i_write_rq;
    assign idx   = i_address[IDX_W+1:2];
    assign unused_addr_bits = &{i_address[31:IDX_W+2], i_address[1:0]};

    cart_config_edge_detect u_edge (
        .i_clk    (i_clk),
        .i_clear  (i_reset),
        .i_enable (!i_n64_disabled),
        .i_a      (i_n64_reset),
        .i_b      (i_n64_nmi),
        .o_event  (n64_evt)
    );

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_word
        localparam logic [DATA_W-1:0] RST_W    = RESET_VALUE[k*DATA_W +: DATA_W];
        localparam logic [DATA_W-1:0] WR_W     = WRITE_MASK[k*DATA_W +: DATA_W];
        localparam logic [DATA_W-1:0] CLR_W    = N64_CLEAR_MASK[k*DATA_W +: DATA_W];
        localparam logic [DATA_W-1:0] DEF_W    = DEFER_MASK[k*DATA_W +: DATA_W];
        localparam logic [DATA_W-1:0] IMM_W    = WR_W & ~DEF_W;
        localparam logic [DATA_W-1:0] COMMIT_W = WR_W & DEF_W;
        localparam bit                HAS_DEFER = |COMMIT_W;

        logic              wr_hit;
        logic [DATA_W-1:0] cfg_q;
        logic [DATA_W-1:0] cfg_d;
        logic [DATA_W-1:0] shadow_q;
        logic              pend_q;

        assign wr_hit = wr_en && (idx == IDX_W'(k));

        // Layering order: clear, then deferred commit, then the bus write on top
        always_comb begin
            cfg_d = cfg_q;
            if (n64_evt) begin
                cfg_d = (cfg_d & ~CLR_W) | (RST_W & CLR_W);
                if (pend_q) begin
                    cfg_d = (cfg_d & ~COMMIT_W) | (shadow_q & COMMIT_W);
                end
            end
            if (wr_hit) begin
                cfg_d = (cfg_d & ~IMM_W) | (i_data & IMM_W);
            end
        end

        // A write landing with an event restages the shadow after the old one commits
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                cfg_q    <= RST_W;
                shadow_q <= '0;
                pend_q   <= 1'b0;
            end else begin
                cfg_q <= cfg_d;
                if (wr_hit && HAS_DEFER) begin
                    shadow_q <= i_data & COMMIT_W;
                    pend_q   <= 1'b1;
                end else if (n64_evt) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign cfg_w[k]                     = cfg_q;
        assign pend_w[k]                    = pend_q;
        assign o_config[k*DATA_W +: DATA_W] = cfg_q;
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_PENDING_LSB +: STATUS_PENDING_W] = STATUS_PENDING_W'(pend_w);
        status_word[STATUS_COUNT_LSB +: EVENT_COUNT_W]      = evt_cnt_q;
    end

    always_comb begin
        rd_word = '0;
        if (idx == STATUS_IDX) begin
            rd_word = status_word;
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            if (idx == IDX_W'(k)) begin
                rd_word = cfg_w[k];
            end
        end
    end

    // Stage p1: registered ack, read data and event strobe
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_p1       <= 1'b0;
            rd_data_p1   <= '0;
            n64_event_p1 <= 1'b0;
            evt_cnt_q    <= '0;
        end else begin
            ack_p1       <= req;
            n64_event_p1 <= n64_evt;
            if (req) begin
                rd_data_p1 <= rd_word;
            end
            if (n64_evt) begin
                evt_cnt_q <= sat_inc(evt_cnt_q);
            end
        end
    end

    assign o_ack       = ack_p1;
    assign o_data      = rd_data_p1;
    assign o_n64_event = n64_event_p1;

endmodule

// File: tb/tb_cart_config_bank.sv
// Randomised and directed bench for cart_config_bank against a cycle-level
// behavioural model of the register bank.
module tb_cart_config_bank;

    localparam logic [127:0] RV = {32'h0, 32'h0, 32'h0, 32'h1};
    localparam logic [127:0] WM = {32'h0FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000001F};
    localparam logic [127:0] CM = {32'h0, 32'hF0F0F0F0, 32'h0, 32'h00000007};
    localparam logic [127:0] DM = {32'hFFFF0000, 32'h0, 32'h000000FF, 32'h0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         n64r = 1'b0;
    logic         nmi = 1'b0;
    logic         dis = 1'b0;
    logic         sel = 1'b0;
    logic         rd = 1'b0;
    logic         wr = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  din = '0;
    logic         ack;
    logic [31:0]  dout;
    logic [127:0] cfg;
    logic         evt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_cfg [4];
    logic [31:0] m_sh [4];
    logic [3:0]  m_pend;
    int          m_cnt;
    logic        m_prev_r, m_prev_n;
    logic        e_ack, e_evt;
    logic [31:0] e_data;

    cart_config_bank #(
        .NUM_REGS(4), .DATA_W(32), .IDX_W(4),
        .RESET_VALUE(RV), .WRITE_MASK(WM), .N64_CLEAR_MASK(CM), .DEFER_MASK(DM)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_n64_reset(n64r), .i_n64_nmi(nmi),
        .i_n64_disabled(dis), .i_select(sel), .i_read_rq(rd), .i_write_rq(wr),
        .i_address(addr), .i_data(din), .o_ack(ack), .o_data(dout),
        .o_config(cfg), .o_n64_event(evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input int i);
        if (i < 4) return m_cfg[i];
        if (i == 4) return {12'b0, m_pend, 8'b0, 8'(m_cnt)};
        return 32'h0;
    endfunction

    task automatic model_update();
        int          i;
        logic        ev;
        logic [31:0] w, imm, com;
        i = int'(addr[5:2]);
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_cfg[k] = RV[k*32 +: 32];
                m_sh[k]  = '0;
            end
            m_pend = '0; m_cnt = 0; e_ack = 0; e_data = '0; e_evt = 0;
            m_prev_r = 1'b1; m_prev_n = 1'b1;
        end else begin
            ev = !dis && ((n64r && !m_prev_r) || (nmi && !m_prev_n));
            e_ack = sel && (rd || wr);
            if (e_ack) e_data = mread(i);
            e_evt = ev;
            for (int k = 0; k < 4; k++) begin
                imm = WM[k*32 +: 32] & ~DM[k*32 +: 32];
                com = WM[k*32 +: 32] & DM[k*32 +: 32];
                w = m_cfg[k];
                if (ev) begin
                    w = (w & ~CM[k*32 +: 32]) | (RV[k*32 +: 32] & CM[k*32 +: 32]);
                    if (m_pend[k]) w = (w & ~com) | (m_sh[k] & com);
                end
                if (sel && wr && i == k) w = (w & ~imm) | (din & imm);
                m_cfg[k] = w;
                if (sel && wr && i == k && com != 0) begin
                    m_sh[k] = din & com;
                    m_pend[k] = 1'b1;
                end else if (ev) begin
                    m_pend[k] = 1'b0;
                end
            end
            if (ev && m_cnt < 255) m_cnt++;
            m_prev_r = n64r; m_prev_n = nmi;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("ack", {31'b0, ack}, {31'b0, e_ack});
        check("rdata", dout, e_data);
        check("event", {31'b0, evt}, {31'b0, e_evt});
        for (int k = 0; k < 4; k++) check($sformatf("cfg%0d", k), cfg[k*32 +: 32], m_cfg[k]);
    endtask

    task automatic bus_read(input int i);
        sel = 1; rd = 1; wr = 0; addr = 32'(i) << 2;
        step();
        sel = 0; rd = 0;
    endtask

    task automatic bus_write(input int i, input logic [31:0] d);
        sel = 1; wr = 1; rd = 0; addr = 32'(i) << 2; din = d;
        step();
        sel = 0; wr = 0;
    endtask

    task automatic pulse_nmi();
        nmi = 1; step();
        nmi = 0; step();
    endtask

    initial begin
        logic [31:0] exp_rd [6];
        int          ev_seen;
        exp_rd[0] = 32'h1; exp_rd[1] = 0; exp_rd[2] = 0; exp_rd[3] = 0; exp_rd[4] = 0; exp_rd[5] = 0;

        repeat (3) step();
        rst = 0;
        step();

        // reset contents, back-to-back reads
        sel = 1; rd = 1;
        for (int i = 0; i < 6; i++) begin
            addr = 32'(i) << 2;
            step();
            check($sformatf("reset_read%0d", i), dout, exp_rd[i]);
        end
        sel = 0; rd = 0;
        step();

        bus_write(0, 32'hFFFFFFFF);
        bus_read(0);
        check("write_mask_word0", dout, 32'h0000001F);
        bus_write(4, 32'hFFFFFFFF);
        bus_write(7, 32'hFFFFFFFF);
        check("status_write_ignored", cfg[31:0], 32'h0000001F);

        bus_write(0, 32'h1E);
        n64r = 1;
        step();
        check("clear_word0", cfg[31:0], 32'h19);
        check("event_pulse", {31'b0, evt}, 32'h1);
        ev_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            ev_seen += int'(evt);
        end
        check("hold_no_event", 32'(ev_seen), 32'h0);
        bus_read(4);
        check("status_count1", dout, 32'h00000001);
        n64r = 0;
        step();

        bus_write(1, 32'hAB);
        check("defer_word1_hold", cfg[63:32], 32'h0);
        bus_read(4);
        check("status_pending", dout, 32'h00020001);
        pulse_nmi();
        check("defer_commit", cfg[63:32], 32'hAB);
        bus_read(4);
        check("status_committed", dout, 32'h00000002);

        dis = 1;
        bus_write(1, 32'h55);
        pulse_nmi();
        check("disabled_no_commit", cfg[63:32], 32'hAB);
        bus_read(4);
        check("disabled_status", dout, 32'h00020002);
        dis = 0;
        step();

        bus_write(1, 32'hAB);
        pulse_nmi();
        bus_write(1, 32'hAB);
        sel = 1; wr = 1; rd = 0; addr = 32'h4; din = 32'hCD; n64r = 1;
        step();
        sel = 0; wr = 0;
        check("same_cycle_word1", cfg[63:32], 32'hAB);
        bus_read(4);
        check("same_cycle_pending", dout & 32'hFFFF0000, 32'h00020000);
        n64r = 0;
        step();
        pulse_nmi();
        check("same_cycle_commit", cfg[63:32], 32'hCD);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            sel = (r < 60);
            rd = 1'($urandom);
            wr = 1'($urandom);
            addr = ($urandom & 32'hFFFFFFC3) | (32'($urandom_range(0, 7)) << 2);
            din = $urandom;
            if ($urandom_range(0, 99) < 6) n64r = ~n64r;
            if ($urandom_range(0, 99) < 6) nmi = ~nmi;
            if ($urandom_range(0, 99) < 3) dis = ~dis;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0; sel = 0; rd = 0; wr = 0; dis = 0; n64r = 0; nmi = 0;
        step();

        for (int n = 0; n < 260; n++) pulse_nmi();
        bus_read(4);
        check("count_saturate", dout & 32'hFF, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
